// File: rtl/axis_width_upsizer.sv
// axis_width_upsizer
//   Packs AXIS_RATIO consecutive narrow AXI-Stream beats into one wide beat.
//   A tlast beat closes the wide word early. Lanes that were never filled
//   carry data 0 and keep/strb 0. tid/tdest come from lane 0 of each word.
//   tuser is the OR of all beats in the word.
//
// Optional feature: define AXIS_UPSIZER_PKT_LEN_EN to add a per-packet count
//   of kept narrow beats (o_pkt_len / o_pkt_len_valid).
//
// Ports:
//   i_clk, i_rst_n        clock, asynchronous active-low reset
//   i_s_axis_*            narrow slave stream (tdata AXIS_S_TDATA_WIDTH bits)
//   o_s_axis_tready       narrow ready
//   o_m_axis_*            wide master stream (tdata AXIS_S_TDATA_WIDTH*AXIS_RATIO,
//                         tkeep/tstrb AXIS_RATIO bits, lane 0 in the LSBs)
//   i_m_axis_tready       wide ready
//   o_pkt_len[_valid]     packet length, only with AXIS_UPSIZER_PKT_LEN_EN
module axis_width_upsizer #(
  parameter int AXIS_S_TDATA_WIDTH = 8,
  parameter int AXIS_RATIO         = 4,
  parameter int PKT_LEN_WIDTH      = 16
) (
  input  logic                                       i_clk,
  input  logic                                       i_rst_n,
  input  logic                                       i_s_axis_tvalid,
  output logic                                       o_s_axis_tready,
  input  logic [AXIS_S_TDATA_WIDTH-1:0]              i_s_axis_tdata,
  input  logic                                       i_s_axis_tlast,
  input  logic                                       i_s_axis_tstrb,
  input  logic                                       i_s_axis_tkeep,
  input  logic                                       i_s_axis_tid,
  input  logic                                       i_s_axis_tdest,
  input  logic                                       i_s_axis_tuser,
  output logic                                       o_m_axis_tvalid,
  input  logic                                       i_m_axis_tready,
  output logic [AXIS_S_TDATA_WIDTH*AXIS_RATIO-1:0]   o_m_axis_tdata,
  output logic                                       o_m_axis_tlast,
  output logic [AXIS_RATIO-1:0]                      o_m_axis_tstrb,
  output logic [AXIS_RATIO-1:0]                      o_m_axis_tkeep,
  output logic                                       o_m_axis_tid,
  output logic                                       o_m_axis_tdest,
  output logic                                       o_m_axis_tuser
`ifdef AXIS_UPSIZER_PKT_LEN_EN
  ,
  output logic [PKT_LEN_WIDTH-1:0]                   o_pkt_len,
  output logic                                       o_pkt_len_valid
`endif
);

  localparam int W     = AXIS_S_TDATA_WIDTH;
  localparam int WW    = AXIS_S_TDATA_WIDTH * AXIS_RATIO;
  localparam int IDX_W = (AXIS_RATIO > 1) ? $clog2(AXIS_RATIO) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(AXIS_RATIO - 1);

  generate
    if (AXIS_RATIO < 2 || (AXIS_RATIO & (AXIS_RATIO - 1)) != 0) begin : g_bad_ratio
      $error("axis_width_upsizer: AXIS_RATIO must be a power of two >= 2");
    end
    if (PKT_LEN_WIDTH < 1) begin : g_bad_len
      $error("axis_width_upsizer: PKT_LEN_WIDTH must be >= 1");
    end
  endgenerate

  logic [IDX_W-1:0]      r_idx;
  logic [WW-1:0]         r_stage_data;
  logic [AXIS_RATIO-1:0] r_stage_keep;
  logic [AXIS_RATIO-1:0] r_stage_strb;
  logic                  r_tid;
  logic                  r_tdest;
  logic                  r_sticky_user;

  logic                  r_m_tvalid;
  logic [WW-1:0]         r_m_tdata;
  logic                  r_m_tlast;
  logic [AXIS_RATIO-1:0] r_m_tkeep;
  logic [AXIS_RATIO-1:0] r_m_tstrb;
  logic                  r_m_tid;
  logic                  r_m_tdest;
  logic                  r_m_tuser;

  logic                  w_s_hs;
  logic                  w_m_hs;
  logic                  w_complete;
  logic [WW-1:0]         w_word_data;
  logic [AXIS_RATIO-1:0] w_word_keep;
  logic [AXIS_RATIO-1:0] w_word_strb;

  // Input stalls whenever a wide beat is pending and not being taken, even
  // mid-word; this keeps staging and output loading on a single condition.
  assign o_s_axis_tready = i_rst_n & (~r_m_tvalid | i_m_axis_tready);
  assign w_s_hs          = i_s_axis_tvalid & o_s_axis_tready;
  assign w_m_hs          = r_m_tvalid & i_m_axis_tready;
  assign w_complete      = (r_idx == LAST_IDX) | i_s_axis_tlast;

  // Completed word: staged lanes below idx, current beat in lane idx, zero above.
  always_comb begin
    w_word_data = '0;
    w_word_keep = '0;
    w_word_strb = '0;
    for (int l = 0; l < AXIS_RATIO; l++) begin
      if (l < int'(r_idx)) begin
        w_word_data[l*W +: W] = r_stage_data[l*W +: W];
        w_word_keep[l]        = r_stage_keep[l];
        w_word_strb[l]        = r_stage_strb[l];
      end else if (l == int'(r_idx)) begin
        w_word_data[l*W +: W] = i_s_axis_tdata;
        w_word_keep[l]        = i_s_axis_tkeep;
        w_word_strb[l]        = i_s_axis_tstrb;
      end
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_idx         <= '0;
      r_stage_data  <= '0;
      r_stage_keep  <= '0;
      r_stage_strb  <= '0;
      r_tid         <= 1'b0;
      r_tdest       <= 1'b0;
      r_sticky_user <= 1'b0;
      r_m_tvalid    <= 1'b0;
      r_m_tdata     <= '0;
      r_m_tlast     <= 1'b0;
      r_m_tkeep     <= '0;
      r_m_tstrb     <= '0;
      r_m_tid       <= 1'b0;
      r_m_tdest     <= 1'b0;
      r_m_tuser     <= 1'b0;
    end else begin
      if (w_m_hs) begin
        r_m_tvalid <= 1'b0;
      end
      if (w_s_hs) begin
        if (w_complete) begin
          // Overrides the tvalid clear above, so a simultaneous take and
          // reload keeps the output stream bubble-free.
          r_m_tvalid    <= 1'b1;
          r_m_tdata     <= w_word_data;
          r_m_tkeep     <= w_word_keep;
          r_m_tstrb     <= w_word_strb;
          r_m_tlast     <= i_s_axis_tlast;
          r_m_tuser     <= r_sticky_user | i_s_axis_tuser;
          r_m_tid       <= (r_idx == '0) ? i_s_axis_tid   : r_tid;
          r_m_tdest     <= (r_idx == '0) ? i_s_axis_tdest : r_tdest;
          r_idx         <= '0;
          r_stage_data  <= '0;
          r_stage_keep  <= '0;
          r_stage_strb  <= '0;
          r_sticky_user <= 1'b0;
        end else begin
          r_stage_data[r_idx*W +: W] <= i_s_axis_tdata;
          r_stage_keep[r_idx]        <= i_s_axis_tkeep;
          r_stage_strb[r_idx]        <= i_s_axis_tstrb;
          r_idx                      <= r_idx + IDX_W'(1);
          if (r_idx == '0) begin
            r_tid         <= i_s_axis_tid;
            r_tdest       <= i_s_axis_tdest;
            r_sticky_user <= i_s_axis_tuser;
          end else begin
            r_sticky_user <= r_sticky_user | i_s_axis_tuser;
          end
        end
      end
    end
  end

  assign o_m_axis_tvalid = r_m_tvalid;
  assign o_m_axis_tdata  = r_m_tdata;
  assign o_m_axis_tlast  = r_m_tlast;
  assign o_m_axis_tkeep  = r_m_tkeep;
  assign o_m_axis_tstrb  = r_m_tstrb;
  assign o_m_axis_tid    = r_m_tid;
  assign o_m_axis_tdest  = r_m_tdest;
  assign o_m_axis_tuser  = r_m_tuser;

`ifdef AXIS_UPSIZER_PKT_LEN_EN
  logic [PKT_LEN_WIDTH-1:0] r_pkt_cnt;
  logic [PKT_LEN_WIDTH-1:0] r_pkt_len;
  logic [PKT_LEN_WIDTH-1:0] w_pkt_cnt_nxt;

  // Saturating count of kept beats, including the current one.
  assign w_pkt_cnt_nxt = (i_s_axis_tkeep && (r_pkt_cnt != '1)) ?
                         r_pkt_cnt + PKT_LEN_WIDTH'(1) : r_pkt_cnt;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_pkt_cnt <= '0;
      r_pkt_len <= '0;
    end else if (w_s_hs) begin
      if (i_s_axis_tlast) begin
        r_pkt_len <= w_pkt_cnt_nxt;
        r_pkt_cnt <= '0;
      end else begin
        r_pkt_cnt <= w_pkt_cnt_nxt;
      end
    end
  end

  // The input stalls while the tlast word is pending, so r_pkt_len still
  // belongs to that word when it is taken.
  assign o_pkt_len       = r_pkt_len;
  assign o_pkt_len_valid = w_m_hs & r_m_tlast;
`endif

endmodule

// File: doc/axis_width_upsizer.md
Name: axis_width_upsizer

Overview:
Downstream of the 8-bit AXI-Stream sync FIFO. Packs AXIS_RATIO consecutive narrow beats into one wide beat for the wider datapath. Closes a wide beat early on tlast and marks unused lanes with per-lane tkeep/tstrb = 0. Sustains one narrow beat per cycle when the wide sink is always ready.

Parameters:
AXIS_S_TDATA_WIDTH, 8, narrow (input) tdata width in bits.
AXIS_RATIO, 4, narrow beats per wide beat; power of two, >= 2; elaboration error otherwise.
PKT_LEN_WIDTH, 16, width of the optional packet length counter.

Ports:
i_clk  in  1  clock; the only clock in the block.
i_rst_n  in  1  asynchronous active-low reset.
i_s_axis_tvalid  in  1  narrow beat valid.
o_s_axis_tready  out  1  narrow beat ready.
i_s_axis_tdata  in  AXIS_S_TDATA_WIDTH  narrow data.
i_s_axis_tlast  in  1  end of packet.
i_s_axis_tstrb  in  1  lane strobe.
i_s_axis_tkeep  in  1  lane keep.
i_s_axis_tid  in  1  stream id.
i_s_axis_tdest  in  1  destination.
i_s_axis_tuser  in  1  user sideband.
o_m_axis_tvalid  out  1  wide beat valid.
i_m_axis_tready  in  1  wide beat ready.
o_m_axis_tdata  out  AXIS_S_TDATA_WIDTH*AXIS_RATIO  wide data; lane 0 in the LSBs.
o_m_axis_tlast  out  1  end of packet.
o_m_axis_tstrb  out  AXIS_RATIO  per-lane strobe.
o_m_axis_tkeep  out  AXIS_RATIO  per-lane keep.
o_m_axis_tid  out  1  stream id.
o_m_axis_tdest  out  1  destination.
o_m_axis_tuser  out  1  user sideband.

Behaviour:
- Reset: one clock (i_clk); reset i_rst_n is asynchronous, active-low. While i_rst_n = 0, every o_m_axis_* output is 0, o_s_axis_tready = 0, lane index = 0, staging register is cleared. Reset mid-word discards the partial word; no output is produced for it.
- o_s_axis_tready = i_rst_n & (!o_m_axis_tvalid | i_m_axis_tready). This is combinational from registered state and i_m_axis_tready. There is no combinational path from i_s_axis_tvalid to o_s_axis_tready.
- Lane index idx: log2(AXIS_RATIO) bits. It increments on each narrow handshake and wraps to 0 when the wide beat completes.
- Narrow handshake on a non-completing beat (idx != AXIS_RATIO-1 and tlast = 0):
  - Write tdata, tkeep and tstrb into staging lane idx.
  - When idx = 0, latch tid and tdest; tid/tdest are taken from lane 0 only.
  - OR tuser into the sticky user bit; the sticky bit clears at word start.
- Completing handshake (idx = AXIS_RATIO-1 or tlast = 1):
  - Load the output register with the staged lanes plus the current beat in lane idx.
  - Lanes above idx get data 0, keep 0, strb 0.
  - tlast = i_s_axis_tlast; tuser = sticky | i_s_axis_tuser.
  - Set o_m_axis_tvalid = 1; idx <= 0; clear staging.
- Latency: the wide beat is valid on the cycle after its completing narrow handshake.
- Output handshake (tvalid & tready) without a simultaneous completing handshake: o_m_axis_tvalid <= 0.
- Simultaneous output handshake and completing handshake: the output register reloads and tvalid stays 1, so there is no bubble.
- Back-pressure: while o_m_axis_tvalid = 1 and i_m_axis_tready = 0, o_s_axis_tready = 0.
  - This also holds for non-completing beats. Staging is stalled by design to keep the control logic simple.
- Single-beat packet (tlast with idx = 0): o_m_axis_tkeep = 'b0001, only lane 0 is populated.
- Output payload is stable while tvalid = 1 and tready = 0.

Optional Feature:
Macro AXIS_UPSIZER_PKT_LEN_EN.
- Defined:
  - Adds ports o_pkt_len (out, PKT_LEN_WIDTH) and o_pkt_len_valid (out, 1).
  - A counter increments on every narrow handshake with i_s_axis_tkeep = 1. It saturates at all-ones and clears after the tlast handshake.
  - On the tlast narrow handshake, o_pkt_len <= final count (including this beat). o_pkt_len_valid pulses high for exactly the cycle in which the corresponding tlast wide beat handshakes on the master side.
  - Both reset to 0.
- Undefined: the ports, counter and logic are absent; the rest of the block is unchanged.

Test Plan:
- Full-word stream: sink always ready; send bytes 0x01..0x08, tlast on 0x08 -> two wide beats 0x04030201 and 0x08070605, tkeep 'b1111 on both, tlast only on the second, zero bubbles on the input side.
- Partial last word: send 0xAA, 0xBB, 0xCC with tlast on 0xCC -> one beat tdata 0x00CCBBAA, tkeep 'b0111, tstrb 'b0111, tlast = 1.
- Back-pressure: hold i_m_axis_tready = 0 for 5 cycles with a wide beat pending -> o_s_axis_tready = 0 throughout, output payload stable. Release -> beat accepted and input resumes on the same cycle.
- Sideband: tuser = 1 only on lane 2 of a word, and tid = 1 on lane 0 then 0 on later lanes -> o_m_axis_tuser = 1, o_m_axis_tid = 1.
- Reset mid-word: after 2 narrow beats, assert i_rst_n = 0 asynchronously -> tvalid/tready drop immediately. After release, send 4 fresh bytes -> exactly one wide beat containing only the fresh bytes.
- With AXIS_UPSIZER_PKT_LEN_EN: 6-byte packet, byte 3 with tkeep = 0 -> o_pkt_len = 5, o_pkt_len_valid high for one cycle on the second wide beat's handshake.
